seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised, double-buffered 7-segment scan controller for multiplexed common-anode displays.
- Drives DIGITS digits from a flat bus of 6-bit glyph codes.
- Adds brightness PWM, anti-ghosting blanking at each digit change, per-digit blinking, and tear-free frame-synchronous updates.
- Sits between status/UART front-ends, which write display contents, and the board's segment/select pins.

## Interface
- DIGITS, 6: number of multiplexed digits, 1..8.
- SCAN_W, 13: log2 of cycles per digit slot. 8192 cycles at 50 MHz gives ≈1 kHz per-digit refresh with 6 digits. Minimum 4.
- BLANK, 64: dead cycles at the start of each slot, during which all digits are off. Must be < 2**SCAN_W.
- BLINK_W, 24: blink counter width. Blink phase = counter MSB.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- digits  in  6*DIGITS  per digit {dp, code[4:0]}, digit i at [6i+5:6i]. dp is active high.
- blink_en  in  DIGITS  per-digit blink enable.
- load  in  1  one-cycle strobe: capture digits and blink_en into the shadow buffer.
- bright  in  5  duty in 16ths, 0..16; values >16 saturate to 16. Sampled live, not buffered.
- seg_out  out  8  {dp, a, b, c, d, e, f, g}, all active low.
- sel_out  out  DIGITS  digit select, active low, one-hot-low or all ones.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Slot counter `cnt` (SCAN_W bits) increments every cycle. Digit index `idx` increments when `cnt` wraps and wraps from DIGITS-1 to 0. Frame = DIGITS·2**SCAN_W cycles.
- Blink counter (BLINK_W bits) is free running. `ph` = its MSB.
- Shadow buffer:
  - `load` copies digits and blink_en into the shadow and sets `pend`.
  - At frame end (cnt all ones, idx = DIGITS-1) with `pend` = 1: shadow → active, `pend` cleared.
  - Active contents never change mid-frame.
  - If `load` coincides with frame end: the shadow takes the new data, `pend` stays 1, and the commit happens at the next frame end. The stale shadow is not committed that cycle.
  - Repeated `load` before commit: last write wins.
- Digit `idx` is lit when all of the following hold:
  - cnt ≥ BLANK;
  - cnt[SCAN_W-1:SCAN_W-4] < min(bright, 16);
  - !(blink_en_act[idx] && ph).
  - bright = 16 means lit for the whole slot except the blank window.
- When lit:
  - sel_out = all ones except bit idx = 0.
  - seg_out[6:0] = glyph(code); seg_out[7] = !dp.
- When not lit: sel_out = all ones, seg_out = 8'hFF.
- Glyph table (team standard 5-bit code), {a..g} active low:
  - 0–9, A b C d E F: hex digits.
  - 16–28: G H I J L N O P R S U y Z.
  - 29: blank. 30: '-' (g only, 7'b1111110). 31: blank.
  - Examples: 0 → 0000001, 8 → 0000000, 14 (E) → 0110000.

## Timing
- Reset values:
  - cnt, idx, blink counter, `pend`: 0.
  - Shadow and active entries: {0, 5'd31}; blink_en: 0.
  - sel_out = all ones, seg_out = 8'hFF, frame_tick = 0.
- sel_out, seg_out and frame_tick are registered. Each reflects the counter state of the previous cycle, a fixed latency of 1 cycle.
- frame_tick is high for exactly one cycle, on the cycle after the frame-end counter state, which is the same cycle the commit becomes visible in the active buffer.
- First lit cycle of digit 0 after reset release: cycle BLANK+1. This requires bright > 0 and a committed non-blank glyph.
- bright changes take effect on the next cycle's on/off decision. There is no frame alignment for bright.
- At most one sel_out bit is low at any cycle. All ones for ≥ BLANK cycles between two different low bits.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). Pending loads are discarded.

## Test plan
All scenarios use DIGITS=4, SCAN_W=4, BLANK=2, BLINK_W=8 (64-cycle frame).
- Reset, then load digits {3, 2, 1, 0} with bright=16 → nothing lit until the first frame_tick. Next frame: digit 0 shows 0000001 with sel_out=1110 on cycles 2..15 of its slot, then digit 1 (1001111) with sel_out=1101, and so on. seg_out = FF during blank cycles.
- bright=4, digit 2 = 8 → sel_out=1011 only on slot cycles 2..3. bright=0 → never lit. bright=20 → same as 16.
- load at cycle 30 of a frame → outputs unchanged until frame end, new data from the following frame. Load exactly on the frame-end cycle → commit delayed one full frame.
- blink_en=0010 committed → digit 1 dark whenever blink MSB = 1 (128-cycle halves), other digits unaffected.
- dp=1, code 30 → seg_out = 0_1111110 while lit. Code 29 or 31 → segments 1111111 with select still low.
- Assert rst mid-slot with pend=1 → immediate sel_out=1111, seg_out=FF. After release, all digits blank until a new load and commit.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered multiplexed 7-segment scan controller
module seg_scan_ctrl #(
  parameter int DIGITS  = 6,
  parameter int SCAN_W  = 13,
  parameter int BLANK   = 64,
  parameter int BLINK_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  load,
  input  logic [4:0]            bright,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_tick
);

  localparam int                IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]     LAST_IDX    = IW'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] BLANK_C     = SCAN_W'(BLANK);
  localparam logic [5:0]        BLANK_ENTRY = 6'b011111;

  logic [SCAN_W-1:0]   cnt;
  logic [IW-1:0]       idx;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                ph;
  logic                pend;
  logic [6*DIGITS-1:0] shd_dig;
  logic [DIGITS-1:0]   shd_blk;
  logic [6*DIGITS-1:0] act_dig;
  logic [DIGITS-1:0]   act_blk;

  logic                frame_end;
  logic [5:0]          entry;
  logic                entry_blk;
  logic [4:0]          bright_sat;
  logic                lit;
  logic [DIGITS-1:0]   sel_lit;

  // Glyph ROM: 5-bit code to {a..g}, active low
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'b0000001;
      5'd1:    glyph = 7'b1001111;
      5'd2:    glyph = 7'b0010010;
      5'd3:    glyph = 7'b0000110;
      5'd4:    glyph = 7'b1001100;
      5'd5:    glyph = 7'b0100100;
      5'd6:    glyph = 7'b0100000;
      5'd7:    glyph = 7'b0001111;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0000100;
      5'd10:   glyph = 7'b0001000;  // A
      5'd11:   glyph = 7'b1100000;  // b
      5'd12:   glyph = 7'b0110001;  // C
      5'd13:   glyph = 7'b1000010;  // d
      5'd14:   glyph = 7'b0110000;  // E
      5'd15:   glyph = 7'b0111000;  // F
      5'd16:   glyph = 7'b0100001;  // G
      5'd17:   glyph = 7'b1001000;  // H
      5'd18:   glyph = 7'b1001111;  // I
      5'd19:   glyph = 7'b1000011;  // J
      5'd20:   glyph = 7'b1110001;  // L
      5'd21:   glyph = 7'b0001001;  // N
      5'd22:   glyph = 7'b0000001;  // O
      5'd23:   glyph = 7'b0011000;  // P
      5'd24:   glyph = 7'b1111010;  // R (lower-case r)
      5'd25:   glyph = 7'b0100100;  // S
      5'd26:   glyph = 7'b1000001;  // U
      5'd27:   glyph = 7'b1000100;  // y
      5'd28:   glyph = 7'b0010010;  // Z
      5'd30:   glyph = 7'b1111110;  // '-'
      default: glyph = 7'b1111111;  // 29, 31: blank
    endcase
  endfunction

  assign frame_end = (cnt == '1) && (idx == LAST_IDX);
  assign ph        = blink_cnt[BLINK_W-1];

  // Select the active entry for the current digit and decide whether it is lit
  always_comb begin
    entry      = BLANK_ENTRY;
    entry_blk  = 1'b0;
    sel_lit    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        entry      = act_dig[6*i +: 6];
        entry_blk  = act_blk[i];
        sel_lit[i] = 1'b0;
      end
    end
    bright_sat = (bright > 5'd16) ? 5'd16 : bright;
    lit        = (cnt >= BLANK_C)
              && ({1'b0, cnt[SCAN_W-1 -: 4]} < bright_sat)
              && !(entry_blk && ph);
  end

  // Slot, digit and blink counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      cnt       <= cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (cnt == '1)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Shadow capture and frame-synchronous commit; a load on the frame-end
  // cycle wins over the commit so the fresh data waits a full frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd_dig <= {DIGITS{BLANK_ENTRY}};
      shd_blk <= '0;
      act_dig <= {DIGITS{BLANK_ENTRY}};
      act_blk <= '0;
      pend    <= 1'b0;
    end else begin
      if (load) begin
        shd_dig <= digits;
        shd_blk <= blink_en;
        pend    <= 1'b1;
      end else if (frame_end && pend) begin
        act_dig <= shd_dig;
        act_blk <= shd_blk;
        pend    <= 1'b0;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out    <= 8'hFF;
      sel_out    <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= lit ? {~entry[5], glyph(entry[4:0])} : 8'hFF;
      sel_out    <= lit ? sel_lit : '1;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [23:0] digits;
  logic [3:0]  blink_en;
  logic        load;
  logic [4:0]  bright;
  logic [7:0]  seg_out;
  logic [3:0]  sel_out;
  logic        frame_tick;

  int checks;
  int errors;
  int e;

  seg_scan_ctrl #(
    .DIGITS  (4),
    .SCAN_W  (4),
    .BLANK   (2),
    .BLINK_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_en   (blink_en),
    .load       (load),
    .bright     (bright),
    .seg_out    (seg_out),
    .sel_out    (sel_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] mk(input int code, input logic dp);
    mk = {dp, 5'(code)};
  endfunction

  task automatic tick();
    @(posedge clk);
    e = e + 1;
    @(negedge clk);
  endtask

  task automatic goto(input int k);
    while (e < k) tick();
  endtask

  task automatic do_load(input logic [23:0] d, input logic [3:0] b);
    digits   = d;
    blink_en = b;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] s, input logic [7:0] g, input logic f);
    checks++;
    assert (sel_out === s) else begin
      errors++;
      $error("FAIL %s sel_out=%b expected %b", tag, sel_out, s);
    end
    checks++;
    assert (seg_out === g) else begin
      errors++;
      $error("FAIL %s seg_out=%h expected %h", tag, seg_out, g);
    end
    checks++;
    assert (frame_tick === f) else begin
      errors++;
      $error("FAIL %s frame_tick=%b expected %b", tag, frame_tick, f);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    e        = 0;
    rst      = 1'b0;
    digits   = '0;
    blink_en = '0;
    load     = 1'b0;
    bright   = 5'd16;
    repeat (3) @(negedge clk);
    chk("reset", 4'b1111, 8'hFF, 1'b0);
    rst = 1'b1;
    e   = 0;

    do_load({mk(3, 0), mk(2, 0), mk(1, 0), mk(0, 0)}, 4'b0000);
    chk("pre_commit_blank_win", 4'b1111, 8'hFF, 1'b0);
    goto(5);   chk("pre_commit_blank_glyph", 4'b1110, 8'hFF, 1'b0);
    goto(64);  chk("first_frame_tick", 4'b0111, 8'hFF, 1'b1);
    goto(65);  chk("d0_blank_window", 4'b1111, 8'hFF, 1'b0);
    goto(67);  chk("d0_first_lit", 4'b1110, 8'h81, 1'b0);
    goto(80);  chk("d0_last_lit", 4'b1110, 8'h81, 1'b0);
    goto(81);  chk("d1_blank_window", 4'b1111, 8'hFF, 1'b0);
    goto(83);  chk("d1_lit", 4'b1101, 8'hCF, 1'b0);
    goto(99);  chk("d2_lit", 4'b1011, 8'h92, 1'b0);
    goto(115); chk("d3_lit", 4'b0111, 8'h86, 1'b0);

    goto(158);
    do_load({mk(29, 0), mk(8, 0), mk(8, 0), mk(30, 1)}, 4'b0010);
    goto(163); chk("midframe_load_unchanged", 4'b1011, 8'h92, 1'b0);
    goto(192); chk("commit_tick", 4'b0111, 8'h86, 1'b1);
    goto(195); chk("dash_dp", 4'b1110, 8'h7E, 1'b0);
    goto(211); chk("blink_dark", 4'b1111, 8'hFF, 1'b0);
    goto(227); chk("d2_eight", 4'b1011, 8'h80, 1'b0);
    goto(243); chk("code29_sel_low", 4'b0111, 8'hFF, 1'b0);

    goto(256); bright = 5'd4;
    goto(275); chk("blink_lit_phase", 4'b1101, 8'h80, 1'b0);
    goto(279); chk("bright4_off", 4'b1111, 8'hFF, 1'b0);
    goto(291); chk("bright4_cyc2", 4'b1011, 8'h80, 1'b0);
    goto(292); chk("bright4_cyc3", 4'b1011, 8'h80, 1'b0);
    goto(293); chk("bright4_cyc4_off", 4'b1111, 8'hFF, 1'b0);
    goto(300); bright = 5'd20;
    goto(301); chk("bright20_sat", 4'b1011, 8'h80, 1'b0);
    goto(305); bright = 5'd0;
    goto(307); chk("bright0_off", 4'b1111, 8'hFF, 1'b0);
    goto(310); bright = 5'd16;
    goto(387); chk("blink_other_digit", 4'b1110, 8'h7E, 1'b0);
    goto(403); chk("blink_dark2", 4'b1111, 8'hFF, 1'b0);

    goto(447);
    do_load({mk(29, 0), mk(8, 0), mk(8, 0), mk(14, 0)}, 4'b0000);
    chk("frame_end_load_tick", 4'b0111, 8'hFF, 1'b1);
    goto(449); chk("tick_one_cycle", 4'b1111, 8'hFF, 1'b0);
    goto(451); chk("frame_end_load_deferred", 4'b1110, 8'h7E, 1'b0);
    goto(515); chk("deferred_commit", 4'b1110, 8'hB0, 1'b0);

    goto(520);
    do_load({mk(1, 0), mk(1, 0), mk(1, 0), mk(1, 0)}, 4'b0000);
    goto(525); chk("pre_reset_lit", 4'b1110, 8'hB0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset", 4'b1111, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    e   = 0;
    goto(64);  chk("post_reset_tick", 4'b0111, 8'hFF, 1'b1);
    goto(67);  chk("pending_discarded", 4'b1110, 8'hFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
